ft245_rx_reader: RTL and testbench

Synchronous FT245 FIFO read controller: pulls bytes from the FTDI chip (host → FPGA direction) and delivers them to fabric logic over a valid/ready byte stream. It is the receive counterpart of the existing FT245 transmit/counter path and shares its 60 MHz FTDI clock domain. Downstream backpressure must never drop or duplicate a byte, so a small internal FIFO absorbs the strobed reads.

---
 rtl/ft245_rx_reader.sv | 103 ++++++++++
 tb/tb_ft245_rx_reader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ft245_rx_reader.sv
// Synchronous FT245 FIFO read controller: strobes bytes out of the FTDI receive
// FIFO into a small first-word-fall-through buffer presented as a valid/ready stream.
module ft245_rx_reader #(
  parameter int DEPTH = 4
) (
  input  logic       clock_60mhz,
  input  logic       reset_n,
  input  logic [7:0] data,
  input  logic       rx_empty,
  output logic       read_n,
  output logic       output_enable_n,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_active_led_n
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);
  localparam logic [PW:0] MIN_FREE = (PW+1)'(2);

  typedef enum logic [1:0] {IDLE, OE, READ} state_t;

  state_t        state_q, state_d;
  logic          read_n_q, read_n_d;
  logic          oe_n_q, oe_n_d;
  logic          led_n_q, led_n_d;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q, count_d;
  logic [PW:0]   free;
  logic [7:0]    mem_q [DEPTH];
  logic          push, pop;

  // A byte is taken whenever RD# is low and the chip still reports data at this edge.
  assign push     = !read_n_q && !rx_empty;
  assign rx_valid = (count_q != '0);
  assign pop      = rx_valid && rx_ready;
  assign free     = DEPTH_C - count_q;
  assign count_d  = count_q + (PW+1)'(push) - (PW+1)'(pop);

  assign read_n          = read_n_q;
  assign output_enable_n = oe_n_q;
  assign rx_active_led_n = led_n_q;
  assign rx_data         = rx_valid ? mem_q[rd_ptr_q] : 8'h00;

  always_ff @(posedge clock_60mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      read_n_q <= 1'b1;
      oe_n_q   <= 1'b1;
      led_n_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      read_n_q <= read_n_d;
      oe_n_q   <= oe_n_d;
      led_n_q  <= led_n_d;
    end
  end

  // Leaving READ when the buffer would be full keeps every strobed byte storable.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (!rx_empty && (free >= MIN_FREE)) state_d = OE;
      OE:   state_d = rx_empty ? IDLE : READ;
      READ: if (rx_empty || (count_d == DEPTH_C)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    read_n_d = 1'b1;
    oe_n_d   = 1'b1;
    led_n_d  = 1'b1;
    case (state_d)
      OE: oe_n_d = 1'b0;
      READ: begin
        read_n_d = 1'b0;
        oe_n_d   = 1'b0;
        led_n_d  = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock_60mhz or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset: rx_data is masked while the buffer is empty.
  always_ff @(posedge clock_60mhz) begin
    if (push) mem_q[wr_ptr_q] <= data;
  end

endmodule

// File: tb/tb_ft245_rx_reader.sv
// Self-checking bench: an FTDI host model feeds bytes and a queue scoreboard
// checks the delivered stream, occupancy and strobe timing.
module tb_ft245_rx_reader;

  localparam int DEPTH = 4;

  logic       clock_60mhz = 1'b0;
  logic       reset_n;
  logic [7:0] data;
  logic       rx_empty;
  logic       read_n;
  logic       output_enable_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_active_led_n;

  always #5 clock_60mhz = ~clock_60mhz;

  ft245_rx_reader #(.DEPTH(DEPTH)) dut (
    .clock_60mhz     (clock_60mhz),
    .reset_n         (reset_n),
    .data            (data),
    .rx_empty        (rx_empty),
    .read_n          (read_n),
    .output_enable_n (output_enable_n),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rx_ready        (rx_ready),
    .rx_active_led_n (rx_active_led_n)
  );

  int compared = 0;
  int mismatched = 0;
  byte unsigned hostQ[$];
  byte unsigned sb[$];
  bit   hostGap = 1'b0;
  int   readyMode = 1;
  int   pushCount = 0;
  int   popCount = 0;
  logic [7:0] lastPopped = 8'h00;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkStrobes(input string tag, input logic expRd, input logic expOe, input logic expLed);
    checkOutput({tag, " read_n"}, read_n, expRd);
    checkOutput({tag, " output_enable_n"}, output_enable_n, expOe);
    checkOutput({tag, " rx_active_led_n"}, rx_active_led_n, expLed);
  endtask

  // Host side of the FTDI chip: presents the head byte, RXF# high when nothing to send.
  task automatic applyStimulus();
    rx_empty = hostGap || (hostQ.size() == 0);
    data     = (hostQ.size() != 0) ? hostQ[0] : 8'hEE;
    case (readyMode)
      0:       rx_ready = 1'b0;
      1:       rx_ready = 1'b1;
      default: rx_ready = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  // One clock: sample handshakes mid-cycle, then account transfers just after the edge.
  task automatic tick();
    bit willPush;
    bit willPop;
    @(negedge clock_60mhz);
    willPush = (read_n === 1'b0) && (rx_empty === 1'b0);
    willPop  = (rx_valid === 1'b1) && (rx_ready === 1'b1);
    checkOutput("rx_valid", rx_valid, sb.size() != 0);
    if (sb.size() != 0) checkOutput("rx_data", rx_data, sb[0]);
    @(posedge clock_60mhz);
    #1;
    if (willPop && sb.size() != 0) begin
      lastPopped = sb.pop_front();
      popCount++;
    end
    if (willPush && hostQ.size() != 0) begin
      sb.push_back(hostQ.pop_front());
      pushCount++;
    end
    checkOutput("occupancy within DEPTH", sb.size() <= DEPTH, 1);
    applyStimulus();
  endtask

  initial begin
    int base;
    int popBase;
    int n;
    logic [7:0] expNext;

    reset_n = 1'b0;
    readyMode = 1;
    for (int i = 0; i < 3; i++) hostQ.push_back(8'(8'h10 + i));
    applyStimulus();
    repeat (3) begin
      tick();
      checkStrobes("reset", 1'b1, 1'b1, 1'b1);
    end
    checkOutput("reset rx_data", rx_data, 8'h00);

    reset_n = 1'b1;
    tick();
    checkStrobes("release oe", 1'b1, 1'b0, 1'b1);
    tick();
    checkStrobes("release rd", 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    checkStrobes("burst reading", 1'b0, 1'b0, 1'b0);
    tick();
    checkStrobes("burst exit", 1'b1, 1'b1, 1'b1);
    repeat (3) tick();
    checkOutput("burst pops", popCount, 3);
    checkOutput("burst pushes", pushCount, 3);
    checkOutput("burst last byte", lastPopped, 8'h12);

    readyMode = 0;
    for (int i = 0; i < 10; i++) hostQ.push_back(8'(i));
    applyStimulus();
    base = pushCount;
    popBase = popCount;
    repeat (8) tick();
    checkOutput("backpressure reads", pushCount - base, 4);
    checkOutput("backpressure held", sb.size(), 4);
    checkStrobes("backpressure stalled", 1'b1, 1'b1, 1'b1);
    readyMode = 1;
    applyStimulus();
    n = 0;
    while ((popCount - popBase < 10) && n < 200) begin
      tick();
      n++;
    end
    checkOutput("backpressure delivered", popCount - popBase, 10);
    checkOutput("backpressure last byte", lastPopped, 8'h09);

    for (int i = 0; i < 8; i++) hostQ.push_back(8'(8'h20 + i));
    applyStimulus();
    base = pushCount;
    popBase = popCount;
    n = 0;
    while ((pushCount - base < 2) && n < 20) begin
      tick();
      n++;
    end
    checkOutput("gap first two", pushCount - base, 2);
    hostGap = 1'b1;
    applyStimulus();
    tick();
    checkStrobes("gap exit", 1'b1, 1'b1, 1'b1);
    tick();
    tick();
    checkOutput("gap no capture", pushCount - base, 2);
    hostGap = 1'b0;
    applyStimulus();
    tick();
    checkStrobes("gap oe", 1'b1, 1'b0, 1'b1);
    tick();
    checkStrobes("gap rd", 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("gap resume", pushCount - base, 3);
    n = 0;
    while ((popCount - popBase < 8) && n < 200) begin
      tick();
      n++;
    end
    checkOutput("gap delivered", popCount - popBase, 8);
    checkOutput("gap last byte", lastPopped, 8'h27);

    readyMode = 0;
    for (int i = 0; i < 16; i++) hostQ.push_back(8'(8'h30 + i));
    applyStimulus();
    repeat (4) tick();
    checkStrobes("pre-reset", 1'b0, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    checkStrobes("async reset", 1'b1, 1'b1, 1'b1);
    checkOutput("async reset rx_valid", rx_valid, 1'b0);
    sb.delete();
    hostQ.delete();
    applyStimulus();
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    checkStrobes("post reset idle", 1'b1, 1'b1, 1'b1);

    readyMode = 2;
    for (int i = 0; i < 4096; i++) hostQ.push_back(8'(i));
    applyStimulus();
    popBase = popCount;
    expNext = 8'h00;
    n = 0;
    while ((popCount - popBase < 4096) && n < 60000) begin
      base = popCount;
      hostGap = ($urandom_range(0, 15) == 0);
      tick();
      if (popCount != base) begin
        checkOutput("soak increment", lastPopped, expNext);
        expNext = expNext + 8'h01;
      end
      n++;
    end
    hostGap = 1'b0;
    checkOutput("soak delivered", popCount - popBase, 4096);
    checkOutput("soak host drained", hostQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
